// File: rtl/timer_mmio.sv
// Memory-mapped 64-bit machine timer: mtime/mtimecmp, CTRL, STATUS; reads are combinational (zero latency).
// No backpressure, every access completes in its cycle; optional 8-bit prescaler when TIMER_PRESCALER_EN is defined.
module timer_mmio #(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_en,
  input  logic        wr_en,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        hit,
  output logic        timer_interrupt
);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_STATUS   = 3'd5;

  logic [31:0] offset;
  logic [2:0]  reg_idx;
  logic        wr_hit;
  logic        wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
  logic        rd_mtime_lo;

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic [31:0] shadow;
  logic        en;
  logic        ie;
  logic        pend;
  logic        tick;
  logic        pend_next;
  logic        ie_next;
  logic [7:0]  presc_rd;

  assign offset  = addr - BASE_ADDR;
  assign reg_idx = offset[4:2];
  assign hit     = (offset[31:5] == '0) && (offset[1:0] == 2'b00) && (reg_idx <= IDX_STATUS);

  assign wr_hit      = wr_en & hit;
  assign wr_mtime_lo = wr_hit & (reg_idx == IDX_MTIME_LO);
  assign wr_mtime_hi = wr_hit & (reg_idx == IDX_MTIME_HI);
  assign wr_cmp_lo   = wr_hit & (reg_idx == IDX_CMP_LO);
  assign wr_cmp_hi   = wr_hit & (reg_idx == IDX_CMP_HI);
  assign wr_ctrl     = wr_hit & (reg_idx == IDX_CTRL);
  assign wr_status   = wr_hit & (reg_idx == IDX_STATUS);
  assign rd_mtime_lo = rd_en & hit & (reg_idx == IDX_MTIME_LO);

`ifdef TIMER_PRESCALER_EN
  logic [7:0] presc;
  logic [7:0] presc_cnt;

  assign tick     = en && (presc_cnt == presc);
  assign presc_rd = presc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc     <= 8'h00;
      presc_cnt <= 8'h00;
    end else begin
      if (wr_ctrl) presc <= wdata[15:8];
      // Restart the tick period on any CTRL write so a new PRESC takes effect cleanly.
      if (wr_ctrl || !en || tick) presc_cnt <= 8'h00;
      else                        presc_cnt <= presc_cnt + 8'd1;
    end
  end
`else
  assign tick     = en;
  assign presc_rd = 8'h00;
`endif

  // Compare-set dominates the software clear so a still-true condition is never lost.
  assign pend_next = (mtime >= mtimecmp) | (pend & ~(wr_status & wdata[0]));
  assign ie_next   = wr_ctrl ? wdata[1] : ie;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtime           <= 64'h0;
      mtimecmp        <= 64'hFFFF_FFFF_FFFF_FFFF;
      shadow          <= 32'h0;
      en              <= 1'b0;
      ie              <= 1'b0;
      pend            <= 1'b0;
      timer_interrupt <= 1'b0;
    end else begin
      if (wr_mtime_lo)      mtime <= {mtime[63:32], wdata};
      else if (wr_mtime_hi) mtime <= {wdata, mtime[31:0]};
      else if (tick)        mtime <= mtime + 64'd1;
      if (wr_cmp_lo) mtimecmp[31:0]  <= wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= wdata;
      if (wr_ctrl) begin
        en <= wdata[0];
        ie <= wdata[1];
      end
      pend            <= pend_next;
      timer_interrupt <= pend_next & ie_next;
      if (rd_mtime_lo) shadow <= mtime[63:32];
    end
  end

  always_comb begin
    rdata = 32'h0;
    if (rd_en && hit) begin
      case (reg_idx)
        IDX_MTIME_LO: rdata = mtime[31:0];
        IDX_MTIME_HI: rdata = shadow;
        IDX_CMP_LO:   rdata = mtimecmp[31:0];
        IDX_CMP_HI:   rdata = mtimecmp[63:32];
        IDX_CTRL:     rdata = {16'h0, presc_rd, 6'h0, ie, en};
        IDX_STATUS:   rdata = {31'h0, pend};
        default:      rdata = 32'h0;
      endcase
    end
  end

endmodule

// File: doc/timer_mmio.md
TIMER_MMIO -- requirements
Module: timer_mmio

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, word-aligned base of the 24-byte register window.
REQ-002 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rd_en  input  1  load request from the core's data path.
REQ-005 SHALL have port wr_en  input  1  store request from the core's data path.
REQ-006 SHALL have port addr  input  32  byte address of the access.
REQ-007 SHALL have port wdata  input  32  store data (word accesses only).
REQ-008 SHALL have port rdata  output  32  load data, combinational from addr and current state.
REQ-009 SHALL have port hit  output  1  high when addr is a valid word address in the window.
REQ-010 SHALL have port timer_interrupt  output  1  level machine-timer interrupt to the CSR unit.

Function
REQ-011 Register map, offsets from BASE_ADDR: 0x00 MTIME_LO, 0x04 MTIME_HI, 0x08 MTIMECMP_LO, 0x0C MTIMECMP_HI, 0x10 CTRL, 0x14 STATUS.
REQ-012 hit SHALL be 1 only for those six offsets with addr[1:0]=0; otherwise hit=0, rdata=0, writes ignored.
REQ-013 rdata SHALL equal the addressed register when rd_en=1 and hit=1, else 0; zero read latency.
REQ-014 Writes SHALL take effect at the rising clk edge with wr_en=1 and hit=1; rd_en and wr_en both high: write performed, rdata returns pre-write value.
REQ-015 CTRL[0]=EN (counter run), CTRL[1]=IE (interrupt enable), CTRL[15:8]=PRESC; other bits read 0.
REQ-016 mtime SHALL be a 64-bit counter incrementing by 1 on each tick while EN=1; wraps from 2^64-1 to 0 with carry from LO into HI in the same cycle.
REQ-017 A software write to MTIME_LO/HI SHALL override that half for the cycle; the increment is discarded for that cycle.
REQ-018 A read of MTIME_LO SHALL latch mtime[63:32] into a shadow register; a read of MTIME_HI SHALL return the shadow, giving a tear-free 64-bit read as LO-then-HI.
REQ-019 STATUS[0]=PEND SHALL be set on any cycle where mtime >= mtimecmp (unsigned 64-bit), independent of IE.
REQ-020 Writing 1 to STATUS[0] SHALL clear PEND; if the compare condition still holds in that cycle, set wins.
REQ-021 timer_interrupt SHALL equal PEND AND IE, registered (changes only on clk edge).
REQ-022 Writing mtimecmp to a value above mtime SHALL NOT clear PEND by itself; software clears via STATUS.

Reset
REQ-023 While rst=0: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, CTRL=0, PEND=0, shadow=0, prescaler count=0, timer_interrupt=0.
REQ-024 Reset asserted mid-count SHALL take effect immediately, without waiting for clk; first increment after release occurs no earlier than one tick period after EN is written.

Configuration
REQ-025 Macro TIMER_PRESCALER_EN defined: 8-bit prescaler; a tick occurs every PRESC+1 clk cycles while EN=1; prescaler count resets to 0 when EN=0 or CTRL is written.
REQ-026 Macro TIMER_PRESCALER_EN undefined: no prescaler logic; tick every clk cycle while EN=1; CTRL[15:8] reads 0 and writes to it are ignored.

Verification
REQ-027 Reset release, write CTRL=0x3, mtimecmp=5 (HI=0), no prescaler -> timer_interrupt rises on the edge after mtime reaches 5; STATUS reads 0x1.
REQ-028 mtime preset to 0x0000_0000_FFFF_FFFF, EN=1 -> next tick reads LO=0, HI=1; LO-then-HI read across the carry returns the consistent shadow value.
REQ-029 PEND set, IE=1, write STATUS=1 with mtimecmp still <= mtime -> PEND remains 1; raise mtimecmp, write STATUS=1 -> timer_interrupt=0 next cycle.
REQ-030 TIMER_PRESCALER_EN defined, PRESC=3, EN=1 -> mtime increments exactly once per 4 clk cycles; over 40 cycles mtime=10.
REQ-031 Access at BASE_ADDR+0x18 and BASE_ADDR+0x02 -> hit=0, rdata=0, no register changes; rst pulsed low mid-count -> all state returns to REQ-023 values asynchronously.
